// File: rtl/tri_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_pkg
// Description : Screen-space triangle types shared by the projection, FIFO
//               and draw stages.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int NV_DEF      = 3;

    typedef logic [COORD_W_DEF-1:0] coord_t;
    typedef coord_t [1:0]           vertex_t;    // [0] = X, [1] = Y
    typedef vertex_t [NV_DEF-1:0]   triangle_t;

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Modulo-MOD pointer with enable, synchronous clear and
//               asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int MOD = 100,
    parameter int W   = $clog2(MOD)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] c_LAST = W'(MOD - 1);

    logic [W-1:0] r_cnt;

    // Wrap is an explicit compare so non-power-of-two moduli work.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/triangle_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : triangle_fifo_param
// Description : Parametrised triangle FIFO with occupancy, threshold flags,
//               flush, sticky error flags and registered or show-ahead read.
// Revision    : 1.0 - initial release
// ============================================================================
module triangle_fifo_param
    import tri_pkg::*;
#(
    parameter int DEPTH    = 100,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int NV       = NV_DEF,
    parameter bit FWFT     = 1'b0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               flush,
    input  logic                               w_en,
    input  logic [NV-1:0][1:0][COORD_W-1:0]    triangle_in,
    input  logic                               r_en,
    output logic [NV-1:0][1:0][COORD_W-1:0]    triangle_out,
    output logic                               out_valid,
    output logic                               is_empty,
    output logic                               is_full,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] c_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_AE    = CW'(AE_LEVEL);

    typedef logic [NV-1:0][1:0][COORD_W-1:0] entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_rd_ok;
    logic          w_wr_ok;

    assign is_empty     = (r_count == '0);
    assign is_full      = (r_count == c_DEPTH);
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign w_rd_ok = r_en & ~is_empty & ~flush;
    assign w_wr_ok = w_en & (~is_full | w_rd_ok) & ~flush;

    mod_counter #(.MOD(DEPTH), .W(PW)) u_wr_ptr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_clr   (flush),
        .i_en    (w_wr_ok),
        .o_cnt   (w_wr_ptr)
    );

    mod_counter #(.MOD(DEPTH), .W(PW)) u_rd_ptr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_clr   (flush),
        .i_en    (w_rd_ok),
        .o_cnt   (w_rd_ptr)
    );

    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_ptr] <= triangle_in;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (w_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (r_en && is_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Gate with empty so stale RAM never leaks onto the bus.
            assign triangle_out = is_empty ? '0 : r_mem[w_rd_ptr];
            assign out_valid    = ~is_empty;
        end else begin : g_reg
            entry_t r_dout;
            logic   r_valid;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_dout <= r_mem[w_rd_ptr];
                    end
                end
            end

            assign triangle_out = r_dout;
            assign out_valid    = r_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_triangle_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_triangle_fifo_param
// Description : Self-checking bench; registered and show-ahead instances
//               share stimulus and are compared against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_fifo_param;

    localparam int DEPTH = 100;
    localparam int TW    = 60;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            flush = 1'b0;
    logic            w_en = 1'b0;
    logic            r_en = 1'b0;
    logic [TW-1:0]   tin = '0;

    logic [TW-1:0]   tout0, tout1;
    logic            val0, val1, emp0, emp1, ful0, ful1;
    logic            af0, af1, ae0, ae1, ovf0, ovf1, und0, und1;
    logic [6:0]      cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    triangle_fifo_param #(.FWFT(1'b0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .flush(flush), .w_en(w_en),
        .triangle_in(tin), .r_en(r_en), .triangle_out(tout0),
        .out_valid(val0), .is_empty(emp0), .is_full(ful0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(und0)
    );

    triangle_fifo_param #(.FWFT(1'b1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .flush(flush), .w_en(w_en),
        .triangle_in(tin), .r_en(r_en), .triangle_out(tout1),
        .out_valid(val1), .is_empty(emp1), .is_full(ful1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(und1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tri_all(input int v);
        logic [2:0][1:0][9:0] t;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 2; b++)
                t[a][b] = 10'(v);
        return t;
    endfunction

    // Behavioural model: an ordered queue plus sticky error bits.
    logic [TW-1:0] q[$];
    bit            m_ovf = 0, m_und = 0, m_val0 = 0;
    logic [TW-1:0] m_out0 = '0;

    always @(posedge Clk or negedge Reset_n) begin
        bit rd_ok, wr_ok;
        if (!Reset_n) begin
            q.delete(); m_ovf = 0; m_und = 0; m_val0 = 0; m_out0 = '0;
        end else if (flush) begin
            q.delete(); m_ovf = 0; m_und = 0; m_val0 = 0;
        end else begin
            rd_ok = r_en && (q.size() > 0);
            wr_ok = w_en && ((q.size() < DEPTH) || rd_ok);
            if (w_en && !wr_ok) m_ovf = 1;
            if (r_en && !rd_ok) m_und = 1;
            m_val0 = rd_ok;
            if (rd_ok) m_out0 = q.pop_front();
            if (wr_ok) q.push_back(tin);
        end
    end

    always @(negedge Clk) begin
        int n;
        logic [TW-1:0] hd;
        n  = q.size();
        hd = (n > 0) ? q[0] : '0;
        chk("count0", cnt0, n);          chk("count1", cnt1, n);
        chk("empty0", emp0, n == 0);     chk("empty1", emp1, n == 0);
        chk("full0", ful0, n == DEPTH);  chk("full1", ful1, n == DEPTH);
        chk("afull0", af0, n >= 96);     chk("afull1", af1, n >= 96);
        chk("aempty0", ae0, n <= 4);     chk("aempty1", ae1, n <= 4);
        chk("ovf0", ovf0, m_ovf);        chk("ovf1", ovf1, m_ovf);
        chk("und0", und0, m_und);        chk("und1", und1, m_und);
        chk("valid0", val0, m_val0);     chk("data0", tout0, m_out0);
        chk("valid1", val1, n > 0);      chk("data1", tout1, hd);
    end

    // One cycle of stimulus: inputs applied, one edge, then idled.
    task automatic op(input bit w, input bit r, input bit f, input logic [TW-1:0] d);
        w_en = w; r_en = r; flush = f; tin = d;
        @(posedge Clk); #1;
        w_en = 0; r_en = 0; flush = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_count", cnt0, 0);  chk("rst_empty", emp0, 1);
        chk("rst_ae", ae0, 1);      chk("rst_af", af0, 0);
        chk("rst_valid", val0, 0);  chk("rst_data", tout0, 0);
        chk("rst_data1", tout1, 0);
        Reset_n = 1;

        // Fill with all-coords-equal triangles; overflow on the 101st.
        for (int i = 0; i < 100; i++) begin
            op(1, 0, 0, tri_all(i));
            chk("fill_count", cnt0, i + 1);
            chk("fill_af", af0, (i + 1) >= 96);
        end
        chk("full_flag", ful0, 1);
        chk("full_noovf", ovf0, 0);
        op(1, 0, 0, tri_all(999));
        chk("ovf_set", ovf0, 1);
        chk("ovf_count", cnt0, 100);

        // Drain in order, then underflow.
        for (int i = 0; i < 100; i++) begin
            op(0, 1, 0, '0);
            chk("drain_valid", val0, 1);
            chk("drain_data", tout0, tri_all(i));
        end
        chk("drain_empty", emp0, 1);
        op(0, 1, 0, '0);
        chk("und_set", und0, 1);
        chk("und_valid", val0, 0);

        // Empty with simultaneous read and write: write only.
        op(0, 0, 1, '0);
        op(1, 1, 0, tri_all(7));
        chk("emp_rw_count", cnt0, 1);
        chk("emp_rw_und", und0, 1);
        chk("emp_rw_valid", val0, 0);
        op(0, 0, 1, '0);

        // Wrap-around across 99 -> 0.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 60; i++) op(1, 0, 0, tri_all(300 + 100 * k + i));
            for (int i = 0; i < 60; i++) begin
                op(0, 1, 0, '0);
                chk("wrap_data", tout0, tri_all(300 + 100 * k + i));
            end
        end
        chk("wrap_count", cnt0, 0);

        // Full with simultaneous read and write.
        for (int i = 0; i < 100; i++) op(1, 0, 0, tri_all(600 + i));
        op(1, 1, 0, tri_all(5));
        chk("full_rw_count", cnt0, 100);
        chk("full_rw_ovf", ovf0, 0);
        chk("full_rw_data", tout0, tri_all(600));

        // Overflow, drain to 37, then flush with a write pending.
        op(1, 0, 0, tri_all(1));
        for (int i = 0; i < 63; i++) op(0, 1, 0, '0);
        chk("pre_flush_count", cnt0, 37);
        chk("pre_flush_ovf", ovf0, 1);
        op(1, 0, 1, tri_all(77));
        chk("flush_count", cnt0, 0);
        chk("flush_empty", emp0, 1);
        chk("flush_ovf", ovf0, 0);
        chk("flush_valid1", val1, 0);

        // Show-ahead instance.
        op(1, 0, 0, tri_all(11));
        chk("fwft_a", tout1, tri_all(11));
        chk("fwft_a_valid", val1, 1);
        op(1, 0, 0, tri_all(22));
        chk("fwft_a_hold", tout1, tri_all(11));
        op(0, 1, 0, '0);
        chk("fwft_b", tout1, tri_all(22));
        op(0, 1, 0, '0);
        chk("fwft_empty_valid", val1, 0);

        // Randomised traffic with phases biased towards full and empty.
        for (int k = 0; k < 3000; k++) begin
            int pw, pr;
            pw = ((k / 250) % 2 == 0) ? 75 : 30;
            pr = 100 - pw;
            if (k == 1500) begin
                op(1, 1, 0, tri_all(3));
                Reset_n = 0;
                #1;
                chk("arst_count", cnt0, 0);   chk("arst_empty", emp0, 1);
                chk("arst_valid0", val0, 0);  chk("arst_data0", tout0, 0);
                chk("arst_valid1", val1, 0);  chk("arst_data1", tout1, 0);
                chk("arst_ovf", ovf0, 0);     chk("arst_und", und0, 0);
                @(posedge Clk); #1;
                Reset_n = 1;
            end
            op($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
               $urandom_range(0, 299) == 0,
               {$urandom(), $urandom()});
        end

        repeat (2) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/triangle_fifo_param.md
Name: triangle_fifo_param

Overview:
- Parametrised successor to the projected-triangle FIFO that sits between the projection/fifo-writer stage and the draw rasteriser.
- Generalised in coordinate width, vertex count, depth and read mode (registered or first-word-fall-through).
- Adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Depth need not be a power of two; the default is 100.

Parameters:
DEPTH, 100, number of triangle entries (>=2)
COORD_W, 10, bits per screen coordinate (X or Y)
NV, 3, vertices per primitive
FWFT, 0, 0 = registered read (data one cycle after r_en); 1 = show-ahead (head entry always on triangle_out)
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents and error flags
w_en  in  1  write request
triangle_in  in  NV*2*COORD_W  triangle to write; layout [NV-1:0][1:0][COORD_W-1:0], index 0 = X, 1 = Y
r_en  in  1  read/pop request
triangle_out  out  NV*2*COORD_W  read data
out_valid  out  1  triangle_out holds a valid entry
is_empty  out  1  count == 0
is_full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky; set by a rejected write
underflow  out  1  sticky; set by a rejected read

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Pointers and count cleared; triangle_out = 0; out_valid = 0.
  - is_empty = 1, is_full = 0, almost_empty = 1, almost_full = 0 (unless AF_LEVEL = 0).
  - overflow = underflow = 0.
- Reset mid-operation discards all contents; no partial state survives.
- Pointers:
  - wr_ptr and rd_ptr each range 0..DEPTH-1.
  - Increment wraps explicitly from DEPTH-1 to 0, not by bit overflow.
- Write acceptance:
  - A write is accepted if w_en and (!is_full or a read is accepted the same cycle).
  - Accepted write: mem[wr_ptr] <= triangle_in; wr_ptr advances.
- Read acceptance:
  - A read is accepted if r_en and !is_empty.
  - Empty + simultaneous w_en: the read is rejected and the write is accepted. There is no bypass in either mode.
- Rejected operations:
  - w_en when full with no accepted read sets overflow; data is dropped and pointers are unchanged.
  - r_en when empty sets underflow.
  - Flags stay set until flush or reset.
- count:
  - +1 on write only, -1 on read only, unchanged on both or neither.
  - Status flags are derived combinationally from the registered count.
- FWFT = 0:
  - On an accepted read, triangle_out <= mem[rd_ptr] and out_valid <= 1 on the next edge (1-cycle latency).
  - On a cycle with no accepted read, out_valid <= 0 and triangle_out holds its last value.
- FWFT = 1:
  - triangle_out = mem[rd_ptr] combinationally; out_valid = !is_empty.
  - An accepted r_en pops the head entry, and the next entry appears the following cycle.
  - A write into an empty FIFO is visible on triangle_out one cycle after the write edge.
- flush:
  - Has priority over w_en/r_en in the same cycle.
  - Clears pointers, count, out_valid, overflow and underflow.
  - Memory contents are not cleared.
- Memory has no reset; it is inferred as RAM.

Decomposition:
- Package tri_pkg holds:
  - COORD_W_DEF = 10 and NV_DEF = 3.
  - typedef coord_t, logic [COORD_W-1:0].
  - typedef vertex_t, coord_t [1:0].
  - typedef triangle_t, vertex_t [NV-1:0].
  - These types are shared with draw and fifo_writer.
- One sub-module, mod_counter (parameter MOD): an enable-controlled wrap-around pointer with sync clear and async active-low reset. It is instantiated for wr_ptr and rd_ptr.

Test Plan:
1. Reset, then 100 writes of triangles with all coords = i (i = 0..99) -> count = 100, is_full = 1, almost_full asserted from count 96, overflow = 0. A 101st write sets overflow = 1 and count stays 100.
2. From full, 100 reads (FWFT = 0) -> out_valid pulses each cycle after r_en, with outputs 0..99 in order. Then is_empty = 1; a further r_en sets underflow = 1.
3. Wrap-around: 60 writes, 60 reads, then 60 writes and 60 reads -> order preserved across the pointer wrap at 99->0, and count returns to 0.
4. Simultaneous w_en and r_en when full (count = 100) -> write accepted, count stays 100, no overflow. When empty -> read rejected (underflow = 1), count = 1.
5. FWFT = 1: write A, B into empty FIFO -> triangle_out = A one cycle after the first write. r_en -> B on the next cycle; after a second r_en, out_valid = 0.
6. flush asserted with w_en = 1 at count = 37 and overflow set -> next cycle count = 0, is_empty = 1, overflow = 0, and the write is dropped. Reset_n pulsed low mid-burst -> immediate return to reset values.
